// File: rtl/uart_tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared types and defaults for the UART transmit scheduler
// Rev 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sched_state_t;

  localparam int c_N_REQ_DFLT   = 4;
  localparam int c_DATA_W_DFLT  = 8;
  localparam int c_OWNER_W_DFLT = $clog2(c_N_REQ_DFLT);
  localparam int c_WDOG_W       = 16;

endpackage

`default_nettype wire

// File: rtl/uart_tx_sched_if.sv
// ---------------------------------------------------------------------------
// uart_tx_sched_if : requester / transmitter bundle around the TX scheduler
// Rev 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_tx_sched_if
  import uart_pkg::*;
#(
  parameter int N_REQ  = c_N_REQ_DFLT,
  parameter int DATA_W = c_DATA_W_DFLT
);

  localparam int c_OWNER_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        done;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_done;
  logic [c_OWNER_W-1:0]    owner;
  logic                    busy;
  logic                    err;

  // Producers and the transmitter side
  modport master (
    output req, req_data, tx_done,
    input  grant, done, tx_start, tx_data, owner, busy, err
  );

  // Scheduler side
  modport slave (
    input  req, req_data, tx_done,
    output grant, done, tx_start, tx_data, owner, busy, err
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational rotate-priority encoder, search upward from ptr
// Rev 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  wire logic [N_REQ-1:0] req,
  input  wire logic [IDX_W-1:0] ptr,
  output logic      [IDX_W-1:0] winner,
  output logic                  any
);

  int w_idx;

  // Walk offsets high to low so the smallest offset from ptr is the last write.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    w_idx  = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(ptr) + k) % N_REQ;
      if (req[w_idx]) begin
        winner = IDX_W'(w_idx);
        any    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched : round-robin sharing of one UART transmitter among N_REQ
// producers. Optional watchdog enabled by defining UART_SCHED_WATCHDOG_EN.
// Rev 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ       = c_N_REQ_DFLT,
  parameter int DATA_W      = c_DATA_W_DFLT,
  parameter int TIMEOUT_CYC = 65535
) (
  input wire logic        clk,
  input wire logic        RST,
  uart_tx_sched_if.slave  bus
);

  localparam int                   c_OWNER_W = $clog2(N_REQ);
  localparam logic [c_OWNER_W-1:0] c_LAST    = c_OWNER_W'(N_REQ - 1);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_bad_param
    $error("uart_tx_sched: parameter out of range");
  end

  sched_state_t         r_state;
  logic [c_OWNER_W-1:0] r_ptr;
  logic [c_OWNER_W-1:0] r_owner;
  logic [DATA_W-1:0]    r_tx_data;
  logic [N_REQ-1:0]     r_grant;
  logic                 r_tx_start;

  logic [c_OWNER_W-1:0] w_winner;
  logic                 w_any;
  logic [c_OWNER_W-1:0] w_ptr_next;
  logic [N_REQ-1:0]     w_done;

`ifdef UART_SCHED_WATCHDOG_EN
  localparam logic [c_WDOG_W-1:0] c_WDOG_LIMIT = c_WDOG_W'(TIMEOUT_CYC - 1);

  logic [c_WDOG_W-1:0] r_wdog_cnt;
  logic                r_err;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (c_OWNER_W)
  ) u_arb (
    .req    (bus.req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .any    (w_any)
  );

  assign w_ptr_next = (r_owner == c_LAST) ? '0 : r_owner + 1'b1;

  // done must coincide with tx_done, so it is decoded, not registered.
  always_comb begin
    w_done = '0;
    if (r_state == ST_WAIT_DONE && bus.tx_done) begin
      w_done[r_owner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_tx_data  <= '0;
      r_grant    <= '0;
      r_tx_start <= 1'b0;
`ifdef UART_SCHED_WATCHDOG_EN
      r_wdog_cnt <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_grant    <= '0;
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state    <= ST_LAUNCH;
            r_owner    <= w_winner;
            r_tx_data  <= bus.req_data[w_winner*DATA_W +: DATA_W];
            r_grant    <= N_REQ'(1) << w_winner;
            r_tx_start <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          r_state <= ST_WAIT_DONE;
`ifdef UART_SCHED_WATCHDOG_EN
          r_wdog_cnt <= '0;
`endif
        end
        ST_WAIT_DONE: begin
          // A completion in the timeout cycle still counts as a normal finish.
          if (bus.tx_done) begin
            r_state <= ST_IDLE;
            r_ptr   <= w_ptr_next;
          end
`ifdef UART_SCHED_WATCHDOG_EN
          else if (r_wdog_cnt == c_WDOG_LIMIT) begin
            r_state <= ST_IDLE;
            r_ptr   <= w_ptr_next;
            r_err   <= 1'b1;
          end else begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant    = r_grant;
  assign bus.done     = w_done;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_data  = r_tx_data;
  assign bus.owner    = r_owner;
  assign bus.busy     = (r_state != ST_IDLE);
`ifdef UART_SCHED_WATCHDOG_EN
  assign bus.err      = r_err;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched : randomized self-checking bench for uart_tx_sched
// Rev 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  uart_tx_sched #(
    .N_REQ       (N),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  int          n_chk;
  int          n_pass;
  int          m_ptr;
  logic [DW-1:0] m_data [N];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rule: first active requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  // Newly raised requesters get fresh random bytes; held ones keep theirs.
  task automatic set_req(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      if (r[i] && !bus.req[i]) begin
        m_data[i] = DW'($urandom);
        bus.req_data[i*DW +: DW] = m_data[i];
      end
    end
    bus.req = r;
  endtask

  task automatic run_txn(input int lat, input bit drop, input logic [N-1:0] pulse, input string tag);
    int            w;
    logic [N-1:0]  oh;
    logic [N-1:0]  saved;
    w  = pick(bus.req, m_ptr);
    oh = N'(1) << w;
    tick();
    check_eq({tag, "_grant"},    32'(bus.grant),    32'(oh));
    check_eq({tag, "_tx_start"}, 32'(bus.tx_start), 32'd1);
    check_eq({tag, "_tx_data"},  32'(bus.tx_data),  32'(m_data[w]));
    check_eq({tag, "_owner"},    32'(bus.owner),    32'(w));
    if (drop) bus.req[w] = 1'b0;
    tick();
    check_eq({tag, "_grant_pulse"}, 32'(bus.grant),    32'd0);
    check_eq({tag, "_start_pulse"}, 32'(bus.tx_start), 32'd0);
    check_eq({tag, "_busy"},        32'(bus.busy),     32'd1);
    saved   = bus.req;
    bus.req = saved | pulse;
    for (int c = 1; c < lat; c++) begin
      tick();
      bus.req = saved;
      check_eq({tag, "_no_done"}, 32'(bus.done), 32'd0);
    end
    bus.req     = saved;
    bus.tx_done = 1'b1;
    #1;
    check_eq({tag, "_done"},      32'(bus.done),    32'(oh));
    check_eq({tag, "_data_held"}, 32'(bus.tx_data), 32'(m_data[w]));
    tick();
    bus.tx_done = 1'b0;
    check_eq({tag, "_idle"}, 32'(bus.busy), 32'd0);
    m_ptr = (w + 1) % N;
  endtask

  initial begin
    logic [N-1:0] r;
    n_chk  = 0;
    n_pass = 0;
    m_ptr  = 0;
    for (int i = 0; i < N; i++) m_data[i] = '0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_done  = 1'b0;
    RST = 1'b1;
    #2 RST = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_grant",    32'(bus.grant),    32'd0);
    check_eq("rst_done",     32'(bus.done),     32'd0);
    check_eq("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check_eq("rst_busy",     32'(bus.busy),     32'd0);
    check_eq("rst_err",      32'(bus.err),      32'd0);
    check_eq("rst_owner",    32'(bus.owner),    32'd0);
    check_eq("rst_tx_data",  32'(bus.tx_data),  32'd0);
    RST = 1'b1;
    tick();

    // All four held: service order must rotate 0,1,2,3,0.
    set_req(4'b1111);
    for (int k = 0; k < 5; k++) begin
      check_eq("rr_order", 32'(pick(bus.req, m_ptr)), 32'(k % N));
      run_txn(5, 1'b0, '0, "rr");
    end
    set_req('0);

    set_req(4'b0001);
    m_data[0] = 8'hA5;
    bus.req_data[7:0] = 8'hA5;
    run_txn(20, 1'b1, '0, "single");

    // One-cycle req[2] blip during WAIT_DONE must leave no trace.
    set_req(4'b0001);
    run_txn(6, 1'b1, 4'b0100, "blip");
    repeat (3) begin
      tick();
      check_eq("blip_no_grant", 32'(bus.grant), 32'd0);
      check_eq("blip_no_busy",  32'(bus.busy),  32'd0);
    end

    bus.req     = '0;
    bus.tx_done = 1'b1;
    #1;
    check_eq("spur_done", 32'(bus.done), 32'd0);
    tick();
    bus.tx_done = 1'b0;
    check_eq("spur_busy",  32'(bus.busy),     32'd0);
    check_eq("spur_start", 32'(bus.tx_start), 32'd0);

    // Move the pointer away from 0, then reset mid-transfer.
    set_req(4'b0010);
    run_txn(3, 1'b1, '0, "pre_rst");
    set_req(4'b0100);
    tick();
    check_eq("mid_grant", 32'(bus.grant), 32'b0100);
    bus.req = '0;
    tick();
    tick();
    bus.tx_done = 1'b1;
    RST = 1'b0;
    #1;
    check_eq("arst_grant",    32'(bus.grant),    32'd0);
    check_eq("arst_done",     32'(bus.done),     32'd0);
    check_eq("arst_tx_start", 32'(bus.tx_start), 32'd0);
    check_eq("arst_busy",     32'(bus.busy),     32'd0);
    check_eq("arst_owner",    32'(bus.owner),    32'd0);
    check_eq("arst_tx_data",  32'(bus.tx_data),  32'd0);
    tick();
    bus.tx_done = 1'b0;
    RST = 1'b1;
    m_ptr = 0;
    tick();
    set_req(4'b1010);
    run_txn(3, 1'b1, '0, "post_rst_ptr");
    set_req(4'b0100);
    run_txn(3, 1'b1, '0, "post_rst");

    // Withheld completion.
    set_req(4'b0001);
    tick();
    check_eq("wd_grant", 32'(bus.grant), 32'b0001);
    bus.req = '0;
`ifdef UART_SCHED_WATCHDOG_EN
    for (int c = 0; c < TO; c++) begin
      tick();
      check_eq("wd_no_done", 32'(bus.done), 32'd0);
    end
    check_eq("wd_err_pre",  32'(bus.err),  32'd0);
    check_eq("wd_busy_pre", 32'(bus.busy), 32'd1);
    tick();
    check_eq("wd_err",  32'(bus.err),  32'd1);
    check_eq("wd_busy", 32'(bus.busy), 32'd0);
    check_eq("wd_done", 32'(bus.done), 32'd0);
`else
    for (int c = 0; c < 3 * TO; c++) begin
      tick();
      check_eq("wd_no_done", 32'(bus.done), 32'd0);
    end
    check_eq("wd_still_busy", 32'(bus.busy), 32'd1);
    check_eq("wd_err_tied",   32'(bus.err),  32'd0);
    bus.tx_done = 1'b1;
    #1;
    check_eq("wd_late_done", 32'(bus.done), 32'b0001);
    tick();
    bus.tx_done = 1'b0;
`endif
    m_ptr = 1;
    set_req(4'b0011);
    run_txn(4, 1'b1, '0, "after_wd");
`ifdef UART_SCHED_WATCHDOG_EN
    check_eq("err_sticky", 32'(bus.err), 32'd1);
`else
    check_eq("err_zero", 32'(bus.err), 32'd0);
`endif

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req = '0;
        repeat ($urandom_range(1, 3)) begin
          tick();
          check_eq("gap_no_grant", 32'(bus.grant), 32'd0);
        end
      end
      r = N'($urandom_range(1, (1 << N) - 1));
      set_req(r);
      run_txn($urandom_range(2, 8), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0) ? N'($urandom) : '0, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter between `N_REQ` byte producers. It arbitrates, captures the winning byte, and launches the transmitter with a one-cycle start pulse. It then waits for the transmitter's completion pulse and returns a per-requester done strobe. It sits between the producer blocks (CPU bridge, status reporters) and the serial transmitter that shares the bit-rate generator with the receiver.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: byte width; must match the transmitter.
- `TIMEOUT_CYC`, default 65535: watchdog limit in `clk` cycles. Used only when `UART_SCHED_WATCHDOG_EN` is defined.

- `clk`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester transmit request; level, held until `grant`.
- `req_data`  in  N_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]; stable while `req[i]`=1.
- `grant`  out  N_REQ  one-hot, one-cycle pulse: byte accepted.
- `done`  out  N_REQ  one-hot, one-cycle pulse: owner's byte finished on the line.
- `tx_start`  out  1  one-cycle launch pulse to the transmitter.
- `tx_data`  out  DATA_W  registered byte for the transmitter; valid from `tx_start` until `tx_done`.
- `tx_done`  in  1  one-cycle pulse from the transmitter after the stop bit.
- `owner`  out  clog2(N_REQ)  index of the current or last granted requester.
- `busy`  out  1  high in LAUNCH and WAIT_DONE.
- `err`  out  1  sticky watchdog error; cleared only by `RST`. Constant 0 without the macro.

## Operation
- State machine, 3 states:
  - IDLE: no byte in flight.
  - LAUNCH: exactly one cycle.
  - WAIT_DONE: waiting for the transmitter.
- IDLE → LAUNCH when `|req`.
  - Winner = first set `req` bit searching upward from `ptr`, wrapping N_REQ-1 → 0.
  - On that edge: `owner` ← winner, `tx_data` ← winner's slice of `req_data`.
- LAUNCH:
  - `tx_start`=1 and `grant[owner]`=1 for this cycle only.
  - Next state is WAIT_DONE unconditionally.
- WAIT_DONE → IDLE on `tx_done`.
  - Same cycle: `done[owner]`=1.
  - `ptr` ← owner+1 modulo N_REQ.
- A `tx_done` pulse outside WAIT_DONE is ignored.
- `req` changes during LAUNCH or WAIT_DONE are ignored; arbitration happens only in IDLE.
- A requester that keeps `req` high after `grant` is treated as a new request. It is served again only after every other active requester has had a turn.
- `req[i]` dropped before the IDLE edge: no grant, no side effect.
- Reset values:
  - state IDLE, `ptr`=0.
  - `owner`=0, `tx_data`=0.
  - `grant`=0, `done`=0, `tx_start`=0.
  - `busy`=0, `err`=0.
- `RST` asserted mid-transfer: immediate return to IDLE with all outputs at reset values. No `done` is issued. The transmitter is reset by the same `RST`.

## Timing
- `req` first seen high in IDLE at edge t → `grant` and `tx_start` high in cycle t+1 → WAIT_DONE from t+2.
- `tx_done` high in cycle d → `done[owner]` high in the same cycle d (combinational from `tx_done` and state) → IDLE from edge d+1.
- Earliest next `tx_start`: cycle d+2.
- Minimum back-to-back spacing, excluding transmitter time: 3 cycles.
- `grant` and `tx_start` are registered outputs; `done` is combinational.

## Configuration
- `UART_SCHED_WATCHDOG_EN` defined:
  - A 16-bit counter clears on entering WAIT_DONE and increments every WAIT_DONE cycle.
  - At count = TIMEOUT_CYC-1 without `tx_done`: `err` ← 1 (sticky), return to IDLE, `ptr` advances past `owner`, no `done`.
  - `tx_done` in the same cycle as the timeout wins: normal completion, no error.
- Macro undefined:
  - No counter; WAIT_DONE waits indefinitely.
  - `err` is tied to 0.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE, LAUNCH, WAIT_DONE)
  - `DATA_W` default
  - width constant for `owner`
- Sub-module `rr_arbiter`: combinational rotate-priority encoder.
  - Inputs: `req`, `ptr`.
  - Outputs: winner index, `any`.
  - Parameterised by N_REQ; reusable for the receive-side IRQ fan-out.

## Test plan
- Reset, then `req`=0001, `req_data[7:0]`=0xA5 → `grant`=0001 and `tx_start` one cycle later, `tx_data`=0xA5; `tx_done` 20 cycles later → `done`=0001, `busy`=0.
- All four requesters held high, `tx_done` returned 5 cycles after each launch → grants in order 0,1,2,3,0 with `tx_data` matching each slice.
- `req[2]` pulsed for one cycle while WAIT_DONE → no grant to 2 after completion.
- `RST` asserted during WAIT_DONE → all outputs 0 immediately; after release `req`=0100 → grant to 2 (`ptr` back to 0).
- Spurious `tx_done` while IDLE → no `done`, state unchanged.
- With `UART_SCHED_WATCHDOG_EN` and `TIMEOUT_CYC`=16, `tx_done` withheld → `err`=1 after 16 WAIT_DONE cycles, no `done`, next `req` still granted.
